// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: holds the PC, reads one word at a time from the IROM and
// presents it to decode through a single output register with valid/ready.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IROM_AW  = 14
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    output logic               irom_req_o,
    output logic [IROM_AW-1:0] irom_addr_o,
    input  logic               irom_gnt_i,
    input  logic               irom_rvalid_i,
    input  logic [31:0]        irom_rdata_i,
    output logic               inst_valid_o,
    input  logic               inst_ready_i,
    output logic [31:0]        inst_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        pc4_o,
    output logic [24:0]        sext_inst_o
);

    // Handshakes: the IROM request is held until irom_gnt_i and at most one read is
    // outstanding; decode consumes inst_o when inst_valid_o && inst_ready_i at a rising edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FULL = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        kill_q, kill_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            kill_q     <= 1'b0;
            inst_q     <= NOP;
            pc_q       <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            kill_q     <= kill_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        kill_d     = kill_q;
        inst_d     = inst_q;
        pc_d       = pc_q;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (irom_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (irom_rvalid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d     = irom_rdata_i;
                        pc_d       = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (inst_ready_i) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect overrides whatever the state above decided this cycle.
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~32'd3;
            case (state_q)
                S_REQ: begin
                    if (irom_gnt_i) kill_d = 1'b1;
                end
                S_WAIT: begin
                    if (irom_rvalid_i) begin
                        inst_d  = inst_q;
                        pc_d    = pc_q;
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end
                S_FULL: state_d = S_REQ;
                default: ;
            endcase
        end
    end

    assign irom_req_o   = (state_q == S_REQ);
    assign irom_addr_o  = fetch_pc_q[IROM_AW+1:2];
    assign inst_valid_o = (state_q == S_FULL);
    assign inst_o       = inst_q;
    assign pc_o         = pc_q;
    assign pc4_o        = pc_q + 32'd4;
    assign sext_inst_o  = inst_q[31:7];

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed fetch/redirect/reset scenarios followed by a randomized
// run against a program-order PC model and a behavioural IROM.
module tb_ifetch_unit;
  localparam int IROM_AW = 14;

  logic               clk;
  logic               rst;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               irom_req;
  logic [IROM_AW-1:0] irom_addr;
  logic               gnt;
  logic               rvalid;
  logic [31:0]        rdata;
  logic               inst_valid;
  logic               ready;
  logic [31:0]        inst;
  logic [31:0]        pc;
  logic [31:0]        pc4;
  logic [24:0]        sext;

  int checks;
  int failures;
  int cyc;

  ifetch_unit #(.RESET_PC(32'h0000_0000), .IROM_AW(IROM_AW)) dut (
    .clk_i(clk), .rst_i(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .irom_req_o(irom_req), .irom_addr_o(irom_addr), .irom_gnt_i(gnt),
    .irom_rvalid_i(rvalid), .irom_rdata_i(rdata), .inst_valid_o(inst_valid),
    .inst_ready_i(ready), .inst_o(inst), .pc_o(pc), .pc4_o(pc4), .sext_inst_o(sext)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] mem_word(input logic [IROM_AW-1:0] a);
    logic [31:0] w;
    w = {18'h0, a} * 32'h0019_660D;
    return w ^ 32'h1357_9BDF;
  endfunction

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (irom_req !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_ctrl req=%b valid=%b expected req=0 valid=0", tag, irom_req, inst_valid);
    end
    checks++;
    if (inst !== 32'h0000_0013 || pc !== 32'h0 || pc4 !== 32'h4 || sext !== 25'h0) begin
      failures++;
      $display("FAIL %s_data inst=%h pc=%h pc4=%h sext=%h expected 00000013 0 4 0", tag, inst, pc, pc4, sext);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; gnt = 1'b1;
    step();
    step();
    check_reset_outputs("reset");
    gnt = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_first_fetch();
    step();
    rvalid = 1'b0;
    checks++;
    if (irom_req !== 1'b1 || irom_addr !== 14'h0 || inst_valid !== 1'b0 || inst !== 32'h13) begin
      failures++;
      $display("FAIL t1_req req=%b addr=%h valid=%b inst=%h expected 1 0000 0 00000013", irom_req, irom_addr, inst_valid, inst);
    end
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    checks++;
    if (irom_req !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL t1_wait req=%b valid=%b expected 0 0", irom_req, inst_valid);
    end
    rvalid = 1'b1; rdata = 32'h0050_0093;
    step();
    rvalid = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h0050_0093 || pc !== 32'h0 || pc4 !== 32'h4 || sext !== 25'h00A001) begin
      failures++;
      $display("FAIL t1_deliver valid=%b inst=%h pc=%h pc4=%h sext=%h expected 1 00500093 0 4 00a001",
               inst_valid, inst, pc, pc4, sext);
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      gnt = 1'(i % 2); rvalid = 1'b1; rdata = $urandom;
      step();
      checks++;
      if (inst_valid !== 1'b1 || irom_req !== 1'b0 || inst !== 32'h0050_0093 || pc !== 32'h0) begin
        failures++;
        $display("FAIL t2_hold cyc=%0d valid=%b req=%b inst=%h pc=%h expected 1 0 00500093 0", i, inst_valid, irom_req, inst, pc);
      end
    end
    gnt = 1'b0; rvalid = 1'b0; ready = 1'b1;
    step();
    ready = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || irom_req !== 1'b1 || irom_addr !== 14'h1) begin
      failures++;
      $display("FAIL t2_next valid=%b req=%b addr=%h expected 0 1 0001", inst_valid, irom_req, irom_addr);
    end
  endtask

  task automatic fetch_and_check(input string tag, input logic [31:0] word, input logic [31:0] exp_pc);
    gnt = 1'b1;
    step();
    gnt = 1'b0; rvalid = 1'b1; rdata = word;
    step();
    rvalid = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst !== word || pc !== exp_pc || pc4 !== exp_pc + 32'd4) begin
      failures++;
      $display("FAIL %s valid=%b inst=%h pc=%h pc4=%h expected 1 %h %h %h", tag, inst_valid, inst, pc, pc4,
               word, exp_pc, exp_pc + 32'd4);
    end
  endtask

  task automatic test_redirect_wait();
    gnt = 1'b1;
    step();
    gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    checks++;
    if (irom_req !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL t3_wait req=%b valid=%b expected 0 0", irom_req, inst_valid);
    end
    rvalid = 1'b1; rdata = 32'hBAD0_0BAD;
    step();
    rvalid = 1'b0;
    checks++;
    if (irom_req !== 1'b1 || irom_addr !== 14'h40 || inst_valid !== 1'b0 || inst !== 32'h0050_0093 || pc !== 32'h0) begin
      failures++;
      $display("FAIL t3_drop req=%b addr=%h valid=%b inst=%h pc=%h expected 1 0040 0 00500093 0",
               irom_req, irom_addr, inst_valid, inst, pc);
    end
    fetch_and_check("t3_target", 32'h0010_0113, 32'h0000_0100);
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic test_redirect_gnt();
    redirect = 1'b1; redirect_pc = 32'h0000_0200; gnt = 1'b1;
    step();
    redirect = 1'b0; gnt = 1'b0;
    checks++;
    if (irom_req !== 1'b0) begin
      failures++;
      $display("FAIL t4_wait req=%b expected 0", irom_req);
    end
    rvalid = 1'b1; rdata = 32'h0000_0113;
    step();
    rvalid = 1'b0;
    checks++;
    if (irom_req !== 1'b1 || irom_addr !== 14'h80 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL t4_drop req=%b addr=%h valid=%b expected 1 0080 0", irom_req, irom_addr, inst_valid);
    end
    fetch_and_check("t4_target", 32'h0020_0193, 32'h0000_0200);
  endtask

  task automatic test_redirect_full();
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0302;
    step();
    ready = 1'b0; redirect = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || irom_req !== 1'b1 || irom_addr !== 14'hC0 || pc !== 32'h200) begin
      failures++;
      $display("FAIL t5_full req=%b addr=%h valid=%b pc=%h expected 1 00c0 0 200", irom_req, irom_addr, inst_valid, pc);
    end
    gnt = 1'b1;
    step();
    gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0400; rvalid = 1'b1; rdata = 32'h1111_1111;
    step();
    redirect = 1'b0; rvalid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || irom_req !== 1'b1 || irom_addr !== 14'h100 || inst !== 32'h0020_0193) begin
      failures++;
      $display("FAIL t5_wait_rv req=%b addr=%h valid=%b inst=%h expected 1 0100 0 00200193", irom_req, irom_addr, inst_valid, inst);
    end
    fetch_and_check("t5_target", 32'h0030_0213, 32'h0000_0400);
  endtask

  task automatic test_wrap();
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || irom_req !== 1'b1 || irom_addr !== 14'h3FFF) begin
      failures++;
      $display("FAIL wrap_req req=%b addr=%h valid=%b expected 1 3fff 0", irom_req, irom_addr, inst_valid);
    end
    fetch_and_check("wrap_top", 32'h0040_0293, 32'hFFFF_FFFC);
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++;
    if (irom_req !== 1'b1 || irom_addr !== 14'h0) begin
      failures++;
      $display("FAIL wrap_next req=%b addr=%h expected 1 0000", irom_req, irom_addr);
    end
    fetch_and_check("wrap_zero", 32'h0050_0313, 32'h0000_0000);
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    gnt = 1'b1;
    step();
    gnt = 1'b0; rst = 1'b1;
    step();
    check_reset_outputs("t6_reset");
    rst = 1'b0; rvalid = 1'b1; rdata = 32'h7777_7777;
    step();
    rvalid = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h13 || pc !== 32'h0 || irom_req !== 1'b1 || irom_addr !== 14'h0) begin
      failures++;
      $display("FAIL t6_ignore valid=%b inst=%h pc=%h req=%b addr=%h expected 0 00000013 0 1 0000",
               inst_valid, inst, pc, irom_req, irom_addr);
    end
    fetch_and_check("t6_refetch", 32'h0060_0393, 32'h0000_0000);
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  // Randomized run: IROM with random grant/latency plus spurious strobes, random
  // backpressure and redirects. The scoreboard is the program-order PC: each handshake
  // must show the word the IROM holds at the expected PC.
  task automatic test_random();
    logic [31:0]        exp_pc;
    logic [31:0]        exp_inst;
    logic [31:0]        tgt;
    logic [31:0]        exp_q[$];
    logic               pend;
    logic [IROM_AW-1:0] pend_addr;
    int                 lat;
    int                 idle_cnt;
    int                 delivered;
    logic               prev_hold;
    logic [31:0]        prev_pc;
    logic [31:0]        prev_inst;
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; ready = 1'b0; redirect = 1'b0;
    step();
    rst = 1'b0;
    exp_pc = 32'h0; pend = 1'b0; pend_addr = '0; lat = 0;
    idle_cnt = 0; delivered = 0; prev_hold = 1'b0; prev_pc = '0; prev_inst = '0;
    for (int c = 0; c < 4000; c++) begin
      checks++;
      if ((pend && irom_req) || (inst_valid && irom_req)) begin
        failures++;
        $display("FAIL rnd_protocol cyc=%0d req=%b valid=%b outstanding=%b expected no request", cyc, irom_req, inst_valid, pend);
      end
      if (prev_hold) begin
        checks++;
        if (inst_valid !== 1'b1 || pc !== prev_pc || inst !== prev_inst) begin
          failures++;
          $display("FAIL rnd_stable cyc=%0d valid=%b pc=%h inst=%h expected 1 %h %h", cyc, inst_valid, pc, inst, prev_pc, prev_inst);
        end
      end
      gnt = 1'b0; rvalid = 1'b0; rdata = $urandom;
      if (pend) begin
        if (lat == 0) begin
          rvalid = 1'b1; rdata = mem_word(pend_addr); pend = 1'b0;
        end else begin
          lat--;
        end
      end else begin
        if (irom_req && $urandom_range(0, 2) != 0) begin
          gnt = 1'b1; pend = 1'b1; pend_addr = irom_addr; lat = $urandom_range(0, 2);
        end else if (!irom_req) begin
          gnt = ($urandom_range(0, 3) == 0);
        end
        if ($urandom_range(0, 3) == 0) rvalid = 1'b1;
      end
      ready = 1'($urandom_range(0, 1));
      redirect = ($urandom_range(0, 15) == 0);
      tgt = $urandom;
      redirect_pc = tgt;
      if (inst_valid && ready) begin
        exp_q.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect) exp_pc = tgt & ~32'd3;
      while (exp_q.size() > 0) begin
        exp_inst = mem_word(exp_q[0][IROM_AW+1:2]);
        checks++;
        if (pc !== exp_q[0] || inst !== exp_inst || pc4 !== exp_q[0] + 32'd4 || sext !== exp_inst[31:7]) begin
          failures++;
          $display("FAIL rnd_deliver cyc=%0d pc=%h inst=%h pc4=%h sext=%h expected %h %h %h %h", cyc, pc, inst, pc4, sext,
                   exp_q[0], exp_inst, exp_q[0] + 32'd4, exp_inst[31:7]);
        end
        void'(exp_q.pop_front());
        delivered++;
        idle_cnt = 0;
      end
      prev_hold = inst_valid && !ready && !redirect;
      prev_pc = pc;
      prev_inst = inst;
      step();
      idle_cnt++;
      if (idle_cnt > 300) begin
        checks++;
        failures++;
        $display("FAIL rnd_timeout cyc=%0d no instruction delivered for %0d cycles", cyc, idle_cnt);
        break;
      end
    end
    gnt = 1'b0; rvalid = 1'b0; ready = 1'b0; redirect = 1'b0;
    checks++;
    if (delivered < 100) begin
      failures++;
      $display("FAIL rnd_count delivered=%0d expected at least 100", delivered);
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; ready = 1'b0;
    checks = 0; failures = 0; cyc = 0;
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_gnt();
    test_redirect_full();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
